apb_uart_regs: RTL and testbench



---
 rtl/apb_uart_regs.sv | 183 ++++++++++++++++++
 tb/tb_apb_uart_regs.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_regs.sv
`default_nettype none
// ============================================================================
// Module   : apb_uart_regs
// Purpose  : APB3 register front-end for a UART TX/RX pair. The RX storage is
//            a single holding register by default, or a FIFO_DEPTH-entry FIFO
//            when APB_UART_RX_FIFO_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module apb_uart_regs #(
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              rx_en,
    input  logic [7:0]        rx_data,
    input  logic              rx_busy,
    input  logic              rx_done,
    input  logic              rx_error,
    output logic              irq
);

    localparam logic [1:0] c_A_TXDATA = 2'd0;
    localparam logic [1:0] c_A_RXDATA = 2'd1;
    localparam logic [1:0] c_A_STATUS = 2'd2;
    localparam logic [1:0] c_A_CTRL   = 2'd3;

    logic       w_access, w_wr, w_rd, w_tx_busy, w_tx_launch;
    logic       w_push, w_pop, w_frame, w_status_wr;
    logic       w_rx_valid, w_overrun_evt;
    logic [7:0] w_rx_byte;
    logic [3:0] w_cnt4;
    logic [1:0] w_addr;
    logic [31:0] w_rdata;
    logic       w_unused;

    logic       r_tx_en, r_tx_pend, r_frame_err, r_overrun, r_irq;
    logic [7:0] r_tx_data;
    logic [1:0] r_ctrl;

    assign w_addr      = paddr[3:2];
    assign w_access    = psel & penable;
    assign w_wr        = w_access & pwrite;
    assign w_rd        = w_access & ~pwrite;
    assign w_tx_busy   = tx_busy | r_tx_pend;
    assign w_tx_launch = w_wr & (w_addr == c_A_TXDATA) & ~w_tx_busy;
    assign w_push      = rx_done & ~rx_error;
    assign w_frame     = rx_done & rx_error;
    assign w_pop       = w_rd & (w_addr == c_A_RXDATA) & w_rx_valid;
    assign w_status_wr = w_wr & (w_addr == c_A_STATUS);
    assign w_unused    = ^{paddr, pwdata[31:8]};

`ifdef APB_UART_RX_FIFO_EN
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wptr, r_rptr;
    logic [c_CW-1:0] r_count;
    logic            w_full, w_wr_en;
    logic [31:0]     w_cnt_ext;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_full        = (r_count == c_CW'(FIFO_DEPTH));
    assign w_wr_en       = w_push & (~w_full | w_pop);
    assign w_rx_valid    = (r_count != '0);
    assign w_rx_byte     = r_mem[r_rptr];
    assign w_overrun_evt = w_push & w_full & ~w_pop;
    assign w_cnt_ext     = 32'(r_count);
    assign w_cnt4        = (w_cnt_ext > 32'd15) ? 4'hF : w_cnt_ext[3:0];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
`else
    localparam int c_unused_fifo_depth = FIFO_DEPTH;

    logic [7:0] r_hold;
    logic       r_hold_v;

    assign w_rx_valid    = r_hold_v;
    assign w_rx_byte     = r_hold;
    assign w_overrun_evt = w_push & r_hold_v & ~w_pop;
    assign w_cnt4        = 4'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold   <= 8'd0;
            r_hold_v <= 1'b0;
        end else if (w_push & (~r_hold_v | w_pop)) begin
            r_hold   <= rx_data;
            r_hold_v <= 1'b1;
        end else if (w_pop) begin
            r_hold_v <= 1'b0;
        end
    end
`endif

    // Sticky status: a new event wins over a same-cycle W1C clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_en     <= 1'b0;
            r_tx_data   <= 8'd0;
            r_tx_pend   <= 1'b0;
            r_ctrl      <= 2'd0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_tx_en <= w_tx_launch;
            if (w_tx_launch) begin
                r_tx_data <= pwdata[7:0];
                r_tx_pend <= 1'b1;
            end else if (tx_done) begin
                r_tx_pend <= 1'b0;
            end
            if (w_wr & (w_addr == c_A_CTRL)) begin
                r_ctrl <= pwdata[1:0];
            end
            r_frame_err <= w_frame | (r_frame_err & ~(w_status_wr & pwdata[3]));
            r_overrun   <= w_overrun_evt | (r_overrun & ~(w_status_wr & pwdata[4]));
            r_irq       <= r_ctrl[1] & (w_rx_valid | r_frame_err | r_overrun);
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (w_addr)
            c_A_TXDATA: w_rdata = 32'd0;
            c_A_RXDATA: w_rdata = {24'd0, w_rx_valid ? w_rx_byte : 8'd0};
            c_A_STATUS: w_rdata = {20'd0, w_cnt4, 3'd0, r_overrun, r_frame_err,
                                   w_rx_valid, rx_busy, w_tx_busy};
            c_A_CTRL:   w_rdata = {30'd0, r_ctrl};
            default:    w_rdata = 32'd0;
        endcase
    end

    assign prdata  = (w_rd & ~rst) ? w_rdata : 32'd0;
    assign pslverr = ~rst & w_access &
                     (( pwrite & (w_addr == c_A_TXDATA) & w_tx_busy) |
                      (~pwrite & (w_addr == c_A_RXDATA) & ~w_rx_valid));
    assign pready  = 1'b1;
    assign tx_en   = r_tx_en;
    assign tx_data = r_tx_data;
    assign rx_en   = r_ctrl[0];
    assign irq     = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_uart_regs
// Purpose  : Directed and random stimulus for apb_uart_regs, checked against a
//            queue-based reference model of the register behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_uart_regs;

`ifdef APB_UART_RX_FIFO_EN
    localparam bit c_FIFO = 1'b1;
    localparam int c_M    = 4;
`else
    localparam bit c_FIFO = 1'b0;
    localparam int c_M    = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic        tx_busy, tx_done, rx_busy, rx_done, rx_error;
    logic [7:0]  rx_data;
    wire  [31:0] prdata;
    wire         pready, pslverr, tx_en, rx_en, irq;
    wire  [7:0]  tx_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] last_rd;
    logic        last_err;

    // Reference model state
    logic [7:0] mq[$];
    bit         m_fe, m_ov, m_pend, m_txen, m_irq;
    logic [7:0] m_txd;
    logic [1:0] m_ctrl;

    apb_uart_regs #(.ADDR_W(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy),
        .tx_done(tx_done), .rx_en(rx_en), .rx_data(rx_data), .rx_busy(rx_busy),
        .rx_done(rx_done), .rx_error(rx_error), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        int         n;
        logic [3:0] c;
        n = mq.size();
        c = c_FIFO ? ((n > 15) ? 4'hF : 4'(n)) : 4'd0;
        return {20'd0, c, 3'd0, m_ov, m_fe, (n != 0), rx_busy, (tx_busy | m_pend)};
    endfunction

    task automatic model_step();
        logic       acc;
        logic [1:0] a;
        if (rst) begin
            mq.delete();
            m_fe = 0; m_ov = 0; m_pend = 0; m_txen = 0; m_irq = 0;
            m_txd = 8'd0; m_ctrl = 2'd0;
            return;
        end
        acc = psel & penable;
        a   = paddr[3:2];
        m_irq  = m_ctrl[1] && (mq.size() != 0 || m_fe || m_ov);
        m_txen = 0;
        if (acc && pwrite && a == 2'd0 && !(tx_busy || m_pend)) begin
            m_txd = pwdata[7:0]; m_txen = 1; m_pend = 1;
        end else if (tx_done) begin
            m_pend = 0;
        end
        if (acc && pwrite && a == 2'd2) begin
            if (pwdata[3]) m_fe = 0;
            if (pwdata[4]) m_ov = 0;
        end
        if (acc && pwrite && a == 2'd3) m_ctrl = pwdata[1:0];
        if (acc && !pwrite && a == 2'd1 && mq.size() != 0) void'(mq.pop_front());
        if (rx_done && rx_error) m_fe = 1;
        else if (rx_done) begin
            if (mq.size() < c_M) mq.push_back(rx_data);
            else m_ov = 1;
        end
    endtask

    // One clock: check outputs mid-cycle, then advance DUT and model together.
    task automatic cyc();
        logic       acc;
        logic [1:0] a;
        logic [31:0] erd;
        logic       eerr;
        #1;
        acc = psel & penable;
        a   = paddr[3:2];
        erd = 32'd0;
        eerr = 1'b0;
        if (!rst && acc && !pwrite) begin
            case (a)
                2'd1:    erd = (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0;
                2'd2:    erd = m_status();
                2'd3:    erd = {30'd0, m_ctrl};
                default: erd = 32'd0;
            endcase
        end
        if (!rst && acc)
            eerr = pwrite ? (a == 2'd0 && (tx_busy || m_pend)) : (a == 2'd1 && mq.size() == 0);
        if (rst || (acc && !pwrite)) chk("prdata", prdata, erd);
        chk("pslverr", 32'(pslverr), 32'(eerr));
        chk("pready", 32'(pready), 32'd1);
        chk("tx_en", 32'(tx_en), 32'(m_txen));
        chk("tx_data", 32'(tx_data), 32'(m_txd));
        chk("rx_en", 32'(rx_en), 32'(m_ctrl[0]));
        chk("irq", 32'(irq), 32'(m_irq));
        last_rd  = prdata;
        last_err = pslverr;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        cyc();
        penable = 1'b1;
        cyc();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b, input logic err);
        rx_done = 1'b1; rx_data = b; rx_error = err;
        cyc();
        rx_done = 1'b0; rx_error = 1'b0;
    endtask

    initial begin
        rst = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 4'h8;
        pwdata = 32'd0; tx_busy = 1'b1; tx_done = 1'b0; rx_busy = 1'b1;
        rx_done = 1'b0; rx_error = 1'b0; rx_data = 8'd0;
        last_rd = 32'd0; last_err = 1'b0;
        @(negedge clk);

        // Reset held with an active access
        repeat (3) cyc();
        #1;
        chk("rst_status_read", prdata, 32'd0);
        chk("rst_pready", 32'(pready), 32'd1);
        chk("rst_tx_en", 32'(tx_en), 32'd0);
        rst = 1'b0; psel = 1'b0; penable = 1'b0; tx_busy = 1'b0; rx_busy = 1'b0;
        @(negedge clk);

        // TX launch and busy rejection
        apb(1'b1, 4'hC, 32'h3);
        chk("ctrl_rx_en", 32'(rx_en), 32'd1);
        apb(1'b1, 4'h0, 32'hA5);
        chk("tx_pulse", 32'(tx_en), 32'd1);
        chk("tx_byte", 32'(tx_data), 32'hA5);
        cyc();
        chk("tx_pulse_end", 32'(tx_en), 32'd0);
        apb(1'b1, 4'h0, 32'h5A);
        chk("tx_busy_slverr", 32'(last_err), 32'd1);
        chk("tx_busy_no_pulse", 32'(tx_en), 32'd0);
        chk("tx_busy_keep", 32'(tx_data), 32'hA5);
        tx_done = 1'b1; cyc(); tx_done = 1'b0;
        apb(1'b0, 4'h8, 32'd0);
        chk("tx_done_status", 32'(last_rd[0]), 32'd0);

        // RX capture and irq
        rx_pulse(8'h3C, 1'b0);
        cyc();
        chk("rx_irq", 32'(irq), 32'd1);
        apb(1'b0, 4'h4, 32'd0);
        chk("rx_read", last_rd, 32'h3C);
        apb(1'b0, 4'h8, 32'd0);
        chk("rx_valid_clr", 32'(last_rd[2]), 32'd0);
        chk("irq_clr", 32'(irq), 32'd0);

        // Two bytes without a read
        rx_pulse(8'h11, 1'b0);
        rx_pulse(8'h22, 1'b0);
        apb(1'b0, 4'h4, 32'd0);
        chk("first_kept", last_rd, 32'h11);
        apb(1'b0, 4'h8, 32'd0);
        chk("overrun_flag", 32'(last_rd[4]), c_FIFO ? 32'd0 : 32'd1);
        if (c_FIFO) begin
            apb(1'b0, 4'h4, 32'd0);
            chk("second_byte", last_rd, 32'h22);
        end
        apb(1'b1, 4'h8, 32'h10);
        apb(1'b0, 4'h8, 32'd0);
        chk("overrun_w1c", 32'(last_rd[4]), 32'd0);

        // Framing error
        rx_pulse(8'h77, 1'b1);
        apb(1'b0, 4'h8, 32'd0);
        chk("frame_err", 32'(last_rd[3]), 32'd1);
        chk("frame_no_valid", 32'(last_rd[2]), 32'd0);
        apb(1'b0, 4'h4, 32'd0);
        chk("empty_read", last_rd, 32'd0);
        chk("empty_slverr", 32'(last_err), 32'd1);
        apb(1'b1, 4'h8, 32'h08);

        // rx_done coinciding with the RXDATA read
        rx_pulse(8'h44, 1'b0);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h4;
        cyc();
        penable = 1'b1; rx_done = 1'b1; rx_data = 8'h55;
        cyc();
        chk("same_cycle_old", last_rd, 32'h44);
        rx_done = 1'b0; psel = 1'b0; penable = 1'b0;
        apb(1'b0, 4'h8, 32'd0);
        chk("same_cycle_valid", 32'(last_rd[2]), 32'd1);
        chk("same_cycle_no_ovr", 32'(last_rd[4]), 32'd0);
        apb(1'b0, 4'h4, 32'd0);
        chk("same_cycle_new", last_rd, 32'h55);

`ifdef APB_UART_RX_FIFO_EN
        for (int k = 1; k <= 5; k++) rx_pulse(8'(k), 1'b0);
        apb(1'b0, 4'h8, 32'd0);
        chk("fifo_count", 32'(last_rd[11:8]), 32'd4);
        chk("fifo_overrun", 32'(last_rd[4]), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            apb(1'b0, 4'h4, 32'd0);
            chk("fifo_order", last_rd, 32'(k));
        end
        apb(1'b1, 4'h8, 32'h10);
        for (int k = 0; k < 4; k++) rx_pulse(8'hA0 + 8'(k), 1'b0);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h4;
        cyc();
        penable = 1'b1; rx_done = 1'b1; rx_data = 8'hB0;
        cyc();
        chk("fifo_full_pop", last_rd, 32'hA0);
        rx_done = 1'b0; psel = 1'b0; penable = 1'b0;
        apb(1'b0, 4'h8, 32'd0);
        chk("fifo_full_count", 32'(last_rd[11:8]), 32'd4);
        chk("fifo_full_no_ovr", 32'(last_rd[4]), 32'd0);
`endif

        // Random traffic, including occasional mid-operation reset
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            psel     = ($urandom_range(0, 3) != 0);
            penable  = ($urandom_range(0, 1) != 0);
            pwrite   = ($urandom_range(0, 1) != 0);
            paddr    = 4'($urandom);
            pwdata   = $urandom;
            tx_busy  = ($urandom_range(0, 3) == 0);
            tx_done  = ($urandom_range(0, 3) == 0);
            rx_busy  = ($urandom_range(0, 1) != 0);
            rx_done  = ($urandom_range(0, 2) == 0);
            rx_error = ($urandom_range(0, 4) == 0);
            rx_data  = 8'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
